bf_program_loader: RTL and testbench

//  Streams program text from the UART receiver into the single-port program BRAM before the core runs.
//  - Keeps only the eight Brainfuck opcodes and drops all other bytes.
//  - Writes one opcode per BRAM word, then writes a 0x00 terminator word.
//  - Checks bracket balance and reports program length and errors.
//  - Sits between uart_rx and the program BRAM write port; the core holds the BRAM port while busy=0.

---
 rtl/bf_pkg.sv | 29 ++
 rtl/bf_bracket_check.sv | 47 ++++
 rtl/bf_program_loader.sv | 134 +++++++++++++
 tb/tb_bf_program_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Brainfuck opcode constants and helpers, shared by the program loader and the core decoder.
package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;  // +
    localparam logic [7:0] OP_DEC   = 8'h2D;  // -
    localparam logic [7:0] OP_LEFT  = 8'h3C;  // <
    localparam logic [7:0] OP_RIGHT = 8'h3E;  // >
    localparam logic [7:0] OP_LOOP  = 8'h5B;  // [
    localparam logic [7:0] OP_END   = 8'h5D;  // ]
    localparam logic [7:0] OP_OUT   = 8'h2E;  // .
    localparam logic [7:0] OP_IN    = 8'h2C;  // ,
    localparam logic [7:0] OP_HALT  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TERM,
        ST_DONE
    } load_state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        case (b)
            OP_INC, OP_DEC, OP_LEFT, OP_RIGHT,
            OP_LOOP, OP_END, OP_OUT, OP_IN: is_opcode = 1'b1;
            default:                        is_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bf_bracket_check.sv
// Bracket nesting tracker: depth counter plus a sticky imbalance flag.
module bf_bracket_check #(
    parameter int DEPTH_WIDTH = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    input  logic dec,
    input  logic final_check,
    output logic err
);

    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
    logic                   err_q, err_d;

    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        if (clear) begin
            depth_d = '0;
            err_d   = 1'b0;
        end else begin
            if (inc) begin
                depth_d = depth_q + 1'b1;
            end else if (dec) begin
                // A stray ']' is flagged but the counter never goes negative.
                if (depth_q == '0) err_d = 1'b1;
                else               depth_d = depth_q - 1'b1;
            end
            if (final_check && depth_q != '0) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/bf_program_loader.sv
// Filters UART bytes down to Brainfuck opcodes and writes them, plus a 0x00 terminator,
// into the program BRAM; reports length, overflow and bracket imbalance.
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] END_CHAR   = 8'h21
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  err_overflow,
    output logic                  err_unbalanced
);

    // The top word is kept free so the terminator always has somewhere to go.
    localparam logic [ADDR_WIDTH:0] OP_LIMIT = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

    load_state_t           state_q, state_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_overflow_q, err_overflow_d;
    logic                  chk_clear, chk_inc, chk_dec, chk_final;

    always_comb begin
        state_d        = state_q;
        prog_len_d     = prog_len_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        done_d         = done_q;
        err_overflow_d = err_overflow_q;
        chk_clear      = 1'b0;
        chk_inc        = 1'b0;
        chk_dec        = 1'b0;
        chk_final      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d        = ST_LOAD;
                    prog_len_d     = '0;
                    err_overflow_d = 1'b0;
                    done_d         = 1'b0;
                    chk_clear      = 1'b1;
                end
            end
            ST_LOAD: begin
                if (rx_valid) begin
                    if (rx_data == END_CHAR) begin
                        state_d     = ST_TERM;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = prog_len_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = OP_HALT;
                        chk_final   = 1'b1;
                    end else if (is_opcode(rx_data)) begin
                        if (prog_len_q == OP_LIMIT) begin
                            err_overflow_d = 1'b1;
                        end else begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = prog_len_q[ADDR_WIDTH-1:0];
                            mem_wdata_d = rx_data;
                            prog_len_d  = prog_len_q + 1'b1;
                            chk_inc     = (rx_data == OP_LOOP);
                            chk_dec     = (rx_data == OP_END);
                        end
                    end
                end
            end
            ST_TERM: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_LOAD) || (state_d == ST_TERM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            prog_len_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prog_len_q     <= prog_len_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    bf_bracket_check #(
        .DEPTH_WIDTH(ADDR_WIDTH + 1)
    ) u_bracket_check (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (chk_clear),
        .inc         (chk_inc),
        .dec         (chk_dec),
        .final_check (chk_final),
        .err         (err_unbalanced)
    );

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign prog_len     = prog_len_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader with a small (8-word) program memory.
module tb_bf_program_loader;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   prog_len;
    logic          err_overflow;
    logic          err_unbalanced;

    always #5 clk = ~clk;

    bf_program_loader #(
        .ADDR_WIDTH (AW),
        .END_CHAR   (8'h21)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .busy           (busy),
        .done           (done),
        .prog_len       (prog_len),
        .err_overflow   (err_overflow),
        .err_unbalanced (err_unbalanced)
    );

    logic [7:0] mem_model [0:7];
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr] <= mem_wdata;
    end

    typedef struct {
        bit         st;
        logic [7:0] b;
        bit         we;
        logic [2:0] addr;
        logic [7:0] wd;
    } vec_t;

    typedef struct {
        int len;
        bit ovf;
        bit unb;
    } res_t;

    vec_t vq[$];
    res_t rq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic add(input bit st, input logic [7:0] b, input bit we,
                       input logic [2:0] addr, input logic [7:0] wd);
        vec_t v;
        v.st = st; v.b = b; v.we = we; v.addr = addr; v.wd = wd;
        vq.push_back(v);
    endtask

    task automatic add_res(input int len, input bit ovf, input bit unb);
        res_t r;
        r.len = len; r.ovf = ovf; r.unb = unb;
        rq.push_back(r);
    endtask

    initial begin
        int ri;

        // "+[-]!"
        add(1, 8'h2B, 1, 0, 8'h2B); add(0, 8'h5B, 1, 1, 8'h5B); add(0, 8'h2D, 1, 2, 8'h2D);
        add(0, 8'h5D, 1, 3, 8'h5D); add(0, 8'h21, 1, 4, 8'h00); add_res(4, 0, 0);
        // "a+\n b>!"
        add(1, 8'h61, 0, 0, 8'h00); add(0, 8'h2B, 1, 0, 8'h2B); add(0, 8'h0A, 0, 0, 8'h00);
        add(0, 8'h20, 0, 0, 8'h00); add(0, 8'h62, 0, 0, 8'h00); add(0, 8'h3E, 1, 1, 8'h3E);
        add(0, 8'h21, 1, 2, 8'h00); add_res(2, 0, 0);
        // "][!"
        add(1, 8'h5D, 1, 0, 8'h5D); add(0, 8'h5B, 1, 1, 8'h5B); add(0, 8'h21, 1, 2, 8'h00);
        add_res(2, 0, 1);
        // "[[]!"
        add(1, 8'h5B, 1, 0, 8'h5B); add(0, 8'h5B, 1, 1, 8'h5B); add(0, 8'h5D, 1, 2, 8'h5D);
        add(0, 8'h21, 1, 3, 8'h00); add_res(3, 0, 1);
        // "[]!"
        add(1, 8'h5B, 1, 0, 8'h5B); add(0, 8'h5D, 1, 1, 8'h5D); add(0, 8'h21, 1, 2, 8'h00);
        add_res(2, 0, 0);
        // "!" alone
        add(1, 8'h21, 1, 0, 8'h00); add_res(0, 0, 0);

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_err_overflow", err_overflow, 0);
        chk("rst_err_unbalanced", err_unbalanced, 0);
        rst_n = 1'b1;
        tick();

        // rx_valid while idle is ignored
        send(8'h2B);
        chk("idle_rx_we", mem_we, 0);
        chk("idle_rx_busy", busy, 0);
        tick();
        chk("idle_rx_len", prog_len, 0);

        // Reset in the middle of a load
        do_start();
        chk("load_busy", busy, 1);
        send(8'h2B);
        send(8'h2B);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_len", prog_len, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        send(8'h2D);
        chk("after_rst_we", mem_we, 1);
        chk("after_rst_addr", mem_addr, 0);
        chk("after_rst_wdata", mem_wdata, 8'h2D);
        tick();
        send(8'h21);
        chk("after_rst_term_addr", mem_addr, 1);
        chk("after_rst_term_data", mem_wdata, 0);
        tick();
        chk("after_rst_done", done, 1);
        chk("after_rst_len", prog_len, 1);

        // Table-driven loads
        ri = 0;
        foreach (vq[i]) begin
            if (vq[i].st) do_start();
            send(vq[i].b);
            chk($sformatf("v%0d_we", i), mem_we, vq[i].we);
            if (vq[i].we) begin
                chk($sformatf("v%0d_addr", i), mem_addr, vq[i].addr);
                chk($sformatf("v%0d_wdata", i), mem_wdata, vq[i].wd);
            end
            if (vq[i].b == 8'h21) chk($sformatf("v%0d_term_busy", i), busy, 1);
            tick();
            chk($sformatf("v%0d_we_pulse", i), mem_we, 0);
            if (vq[i].b == 8'h21) begin
                chk($sformatf("r%0d_len", ri), prog_len, rq[ri].len);
                chk($sformatf("r%0d_ovf", ri), err_overflow, rq[ri].ovf);
                chk($sformatf("r%0d_unb", ri), err_unbalanced, rq[ri].unb);
                chk($sformatf("r%0d_done", ri), done, 1);
                chk($sformatf("r%0d_busy", ri), busy, 0);
                ri++;
            end
        end

        // start while busy is ignored
        do_start();
        chk("busy_start_done_clr", done, 0);
        send(8'h2B);
        chk("busy_start_addr0", mem_addr, 0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_we", mem_we, 0);
        chk("busy_start_len", prog_len, 1);
        send(8'h3E);
        chk("busy_start_next_we", mem_we, 1);
        chk("busy_start_next_addr", mem_addr, 1);
        tick();
        send(8'h21);
        tick();
        chk("busy_start_final_len", prog_len, 2);

        // rx_valid on the same cycle as an accepted start is dropped
        start = 1'b1;
        rx_data = 8'h2B;
        rx_valid = 1'b1;
        tick();
        start = 1'b0;
        rx_valid = 1'b0;
        chk("same_cycle_we", mem_we, 0);
        chk("same_cycle_busy", busy, 1);
        tick();
        chk("same_cycle_len", prog_len, 0);
        send(8'h21);
        chk("same_cycle_term_addr", mem_addr, 0);
        tick();
        chk("same_cycle_done", done, 1);

        // rx_valid in DONE is ignored
        send(8'h2B);
        chk("done_rx_we", mem_we, 0);
        tick();
        chk("done_rx_len", prog_len, 0);
        chk("done_rx_done", done, 1);

        // Overflow: 7-opcode limit with AW=3
        for (int a = 0; a < 8; a++) mem_model[a] = 8'hFF;
        do_start();
        for (int k = 0; k < 9; k++) begin
            send(8'h2B);
            if (k < 7) begin
                chk($sformatf("ovf_we%0d", k), mem_we, 1);
                chk($sformatf("ovf_addr%0d", k), mem_addr, k);
            end else begin
                chk($sformatf("ovf_drop_we%0d", k), mem_we, 0);
            end
            if (k == 6) chk("ovf_flag_before", err_overflow, 0);
            tick();
        end
        chk("ovf_flag", err_overflow, 1);
        chk("ovf_busy", busy, 1);
        send(8'h5B);
        chk("ovf_bracket_we", mem_we, 0);
        tick();
        send(8'h21);
        chk("ovf_term_we", mem_we, 1);
        chk("ovf_term_addr", mem_addr, 7);
        chk("ovf_term_data", mem_wdata, 0);
        tick();
        chk("ovf_len", prog_len, 7);
        chk("ovf_flag_end", err_overflow, 1);
        chk("ovf_unb", err_unbalanced, 0);
        chk("ovf_done", done, 1);
        for (int a = 0; a < 7; a++) chk($sformatf("ovf_mem%0d", a), mem_model[a], 8'h2B);
        chk("ovf_mem7", mem_model[7], 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
